adc_throttle_writer: RTL and testbench

ADC_THROTTLE_WRITER -- requirements
Module: adc_throttle_writer

---
 rtl/adc_throttle_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_adc_throttle_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_throttle_writer.sv
// -----------------------------------------------------------------------------
// adc_throttle_writer
//
// Purpose:
//   Streams ADC sample words into a memory at a throttled rate. While capture
//   is enabled, one word is written every (interval + 1) cycles to successive
//   addresses. At LAST_ADDR the pointer either wraps to 0 (i_mode = 0) or the
//   writer halts (i_mode = 1) until cleared or reset.
//
// Optional feature:
//   ADC_THROTTLE_DROP_CNT_EN - when defined, o_drop_cnt counts the write slots
//   lost while halted with capture enabled. When undefined, o_drop_cnt is 0.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        synchronous reset, active-high (priority over i_clear)
//   i_en         capture enable, level-sensitive
//   i_clear      one-cycle pulse: clears pointer, counters, flags, FSM to IDLE
//   i_mode       end-of-buffer mode: 0 = wrap, 1 = halt
//   i_interval   idle cycles between successive writes
//   i_data       ADC sample word
//   o_wren       memory write strobe
//   o_addr       memory write address
//   o_wdata      memory write data (0 when o_wren = 0)
//   o_byteen     byte enables (all-ones when writing, else 0)
//   o_full       sticky: halted at LAST_ADDR
//   o_wrapped    sticky: pointer has wrapped at least once
//   o_count      writes since last clear, saturating
//   o_drop_cnt   lost write slots while halted (optional feature)
//   o_dbg_state  current FSM state (0 IDLE, 1 WRITE, 2 WAIT, 3 HALT)
//
// Handshake: there is no back-pressure. A write is issued in every cycle where
// o_wren = 1; the memory must accept it in that same cycle.
// -----------------------------------------------------------------------------
module adc_throttle_writer #(
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 14,
    parameter int unsigned LAST_ADDR = 2**ADDR_W - 1,
    parameter int          IVL_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic                  i_mode,
    input  logic [IVL_W-1:0]      i_interval,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_wren,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_byteen,
    output logic                  o_full,
    output logic                  o_wrapped,
    output logic [ADDR_W:0]       o_count,
    output logic [15:0]           o_drop_cnt,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [IVL_W-1:0]      ivl_q, ivl_d;
    logic [IVL_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  full_q, full_d;
    logic                  wrapped_q, wrapped_d;
    logic                  wren_q, wren_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   byteen_q, byteen_d;
    logic                  halt_now;
`ifdef ADC_THROTTLE_DROP_CNT_EN
    logic [15:0]           drop_q, drop_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ivl_q     <= '0;
            cnt_q     <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            wrapped_q <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            byteen_q  <= '0;
`ifdef ADC_THROTTLE_DROP_CNT_EN
            drop_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ivl_q     <= ivl_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            full_q    <= full_d;
            wrapped_q <= wrapped_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byteen_q  <= byteen_d;
`ifdef ADC_THROTTLE_DROP_CNT_EN
            drop_q    <= drop_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ivl_d     = ivl_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        full_d    = full_q;
        wrapped_d = wrapped_q;
        wren_d    = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        byteen_d  = '0;
        halt_now  = 1'b0;
`ifdef ADC_THROTTLE_DROP_CNT_EN
        drop_d    = drop_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_en) begin
                    state_d = WRITE;
                    ivl_d   = i_interval;
                end
            end

            WRITE: begin
                // Bookkeeping for the write presented during this cycle; it
                // completes even if capture is being dropped on this edge.
                count_d = (&count_q) ? count_q : count_q + 1'b1;
                if (ptr_q == LAST_A) begin
                    if (i_mode) begin
                        halt_now = 1'b1;
                        full_d   = 1'b1;
                        // Drop-slot timer: next slot is ivl+1 cycles after
                        // this write.
                        cnt_d    = ivl_q;
                    end else begin
                        ptr_d     = '0;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end

                if (halt_now) begin
                    state_d = HALT;
                end else if (!i_en) begin
                    state_d = IDLE;
                end else if (ivl_q == '0) begin
                    state_d = WRITE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = ivl_q - 1'b1;
                end
            end

            WAIT: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            HALT: begin
`ifdef ADC_THROTTLE_DROP_CNT_EN
                // Keep the slot cadence running regardless of i_en; only
                // slots that land while capture is enabled are counted.
                if (cnt_q == '0) begin
                    cnt_d = ivl_q;
                    if (i_en && (drop_q != 16'hFFFF)) begin
                        drop_d = drop_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        // Clear overrides any pending write slot.
        if (i_clear) begin
            state_d   = IDLE;
            ptr_d     = '0;
            count_d   = '0;
            full_d    = 1'b0;
            wrapped_d = 1'b0;
`ifdef ADC_THROTTLE_DROP_CNT_EN
            drop_d    = '0;
`endif
        end

        // Outputs are registered from the next state so o_wren is high
        // exactly during the WRITE cycles.
        if (state_d == WRITE) begin
            wren_d   = 1'b1;
            addr_d   = ptr_d;
            wdata_d  = i_data;
            byteen_d = '1;
        end
    end

    assign o_wren      = wren_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_byteen    = byteen_q;
    assign o_full      = full_q;
    assign o_wrapped   = wrapped_q;
    assign o_count     = count_q;
    assign o_dbg_state = state_q;
`ifdef ADC_THROTTLE_DROP_CNT_EN
    assign o_drop_cnt  = drop_q;
`else
    assign o_drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_adc_throttle_writer.sv
// -----------------------------------------------------------------------------
// tb_adc_throttle_writer
//
// Two instances share clock, reset and data inputs but have separate enables:
//   dut_a - default address range, used for throttled ramp and enable-drop.
//   dut_b - LAST_ADDR = 3, used for wrap, halt, reset-in-halt and clear.
// The driver pushes expected writes {cycle, addr, data} into a per-instance
// queue; a monitor per instance pops and compares on every o_wren pulse and
// checks the bus is zero otherwise.
// -----------------------------------------------------------------------------
module tb_adc_throttle_writer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 14;
    localparam int IVL_W  = 8;
    localparam int REC_W  = 32 + ADDR_W + DATA_W;
`ifdef ADC_THROTTLE_DROP_CNT_EN
    localparam int EXP_DROP = 3;
`else
    localparam int EXP_DROP = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en_a, en_b, clear, mode;
    logic [IVL_W-1:0]   interval;
    logic [DATA_W-1:0]  data;

    logic               a_wren, b_wren, a_full, b_full, a_wrapped, b_wrapped;
    logic [ADDR_W-1:0]  a_addr, b_addr;
    logic [DATA_W-1:0]  a_wdata, b_wdata;
    logic [7:0]         a_byteen, b_byteen;
    logic [ADDR_W:0]    a_count, b_count;
    logic [15:0]        a_drop, b_drop;
    logic [1:0]         a_state, b_state;

    adc_throttle_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IVL_W(IVL_W)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_clear(clear), .i_mode(mode),
        .i_interval(interval), .i_data(data),
        .o_wren(a_wren), .o_addr(a_addr), .o_wdata(a_wdata), .o_byteen(a_byteen),
        .o_full(a_full), .o_wrapped(a_wrapped), .o_count(a_count),
        .o_drop_cnt(a_drop), .o_dbg_state(a_state)
    );

    adc_throttle_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAST_ADDR(3), .IVL_W(IVL_W)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_clear(clear), .i_mode(mode),
        .i_interval(interval), .i_data(data),
        .o_wren(b_wren), .o_addr(b_addr), .o_wdata(b_wdata), .o_byteen(b_byteen),
        .o_full(b_full), .o_wrapped(b_wrapped), .o_count(b_count),
        .o_drop_cnt(b_drop), .o_dbg_state(b_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [REC_W-1:0] exp_a_q[$];
    logic [REC_W-1:0] exp_b_q[$];
    logic [REC_W-1:0] rec_a, rec_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] ramp(input int k);
        return {32'hA5A5_5A5A, 32'(k)};
    endfunction

    // Write expected in monitor cycle c carries the data driven in cycle c-1.
    task automatic push_a(input int c, input int addr);
        exp_a_q.push_back({32'(c), ADDR_W'(addr), ramp(c - 1)});
    endtask

    task automatic push_b(input int c, input int addr);
        exp_b_q.push_back({32'(c), ADDR_W'(addr), ramp(c - 1)});
    endtask

    task automatic cmp_write(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [7:0] be,
                             input logic [REC_W-1:0] r);
        check({tag, "_cycle"},  128'(cyc),   128'(r[REC_W-1 -: 32]));
        check({tag, "_addr"},   128'(addr),  128'(r[DATA_W +: ADDR_W]));
        check({tag, "_wdata"},  128'(wdata), 128'(r[DATA_W-1:0]));
        check({tag, "_byteen"}, 128'(be),    128'(8'hFF));
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_wren) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_wren", 128'(a_addr) + 128'd1, 128'd0);
            end else begin
                rec_a = exp_a_q.pop_front();
                cmp_write("a", a_addr, a_wdata, a_byteen, rec_a);
            end
        end else begin
            check("a_idle_bus", 128'({a_wdata, a_byteen}), 128'd0);
        end
    end

    always @(negedge clk) begin
        if (b_wren) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_wren", 128'(b_addr) + 128'd1, 128'd0);
            end else begin
                rec_b = exp_b_q.pop_front();
                cmp_write("b", b_addr, b_wdata, b_byteen, rec_b);
            end
        end else begin
            check("b_idle_bus", 128'({b_wdata, b_byteen}), 128'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
        data = ramp(cyc);
    endtask

    int k0, c5, w, r0;

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clear = 1'b0; mode = 1'b0;
        interval = '0; data = '0;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_a_wren",   128'(a_wren), 0);
        check("rst_a_count",  128'(a_count), 0);
        check("rst_a_drop",   128'(a_drop), 0);
        check("rst_a_state",  128'(a_state), 0);
        check("rst_b_flags",  128'({b_full, b_wrapped}), 0);
        check("rst_b_addr",   128'(b_addr), 0);
        step();
        rst = 1'b0;

        // Throttled ramp: interval 11, pulses every 12 cycles at 0,1,2,3
        step();
        k0 = cyc; interval = 8'd11; en_a = 1'b1;
        for (int j = 0; j < 4; j++) push_a(k0 + 1 + 12 * j, j);
        while (cyc < k0 + 37) step();
        en_a = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("ramp_count", 128'(a_count), 128'd4);

        // Enable dropped during WAIT after address 5, raised 7 cycles later
        step(); rst = 1'b1;
        step(); rst = 1'b0; interval = 8'd3; en_a = 1'b1; k0 = cyc;
        for (int j = 0; j < 6; j++) push_a(k0 + 1 + 4 * j, j);
        c5 = k0 + 21;
        push_a(c5 + 9, 6);
        push_a(c5 + 13, 7);
        while (cyc < c5 + 1) step();
        en_a = 1'b0;
        while (cyc < c5 + 8) step();
        en_a = 1'b1;
        while (cyc < c5 + 13) step();
        en_a = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("resume_count", 128'(a_count), 128'd8);

        // Back-to-back writes with wrap at LAST_ADDR = 3
        step(); rst = 1'b1;
        step(); rst = 1'b0; interval = 8'd0; mode = 1'b0; en_b = 1'b1; k0 = cyc;
        for (int i = 1; i <= 6; i++) push_b(k0 + i, (i - 1) % 4);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 4) begin
                @(negedge clk);
                check("wrap_before", 128'(b_wrapped), 128'd0);
            end
            if (i == 5) begin
                @(negedge clk);
                check("wrap_after", 128'(b_wrapped), 128'd1);
            end
        end
        en_b = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("wrap_count", 128'(b_count), 128'd6);

        // Halt at LAST_ADDR, then dropped slots
        step(); rst = 1'b1;
        step(); rst = 1'b0; interval = 8'd2; mode = 1'b1; en_b = 1'b1; k0 = cyc;
        for (int j = 0; j < 4; j++) push_b(k0 + 1 + 3 * j, j);
        w = k0 + 10;
        while (cyc < w) step();
        @(negedge clk);
        check("halt_full_before", 128'(b_full), 128'd0);
        step();
        @(negedge clk);
        check("halt_full_after", 128'(b_full), 128'd1);
        check("halt_state", 128'(b_state), 128'd3);
        while (cyc < w + 10) step();
        en_b = 1'b0;
        @(negedge clk);
        check("halt_drop", 128'(b_drop), 128'(EXP_DROP));
        check("halt_count", 128'(b_count), 128'd4);
        repeat (3) step();
        @(negedge clk);
        check("halt_drop_hold", 128'(b_drop), 128'(EXP_DROP));
        check("halt_full_hold", 128'(b_full), 128'd1);

        // Reset while halted
        step(); rst = 1'b1;
        step(); rst = 1'b0; en_b = 1'b1; r0 = cyc;
        push_b(r0 + 1, 0);
        @(negedge clk);
        check("hrst_wren",  128'(b_wren), 128'd0);
        check("hrst_flags", 128'({b_full, b_wrapped}), 128'd0);
        check("hrst_count", 128'(b_count), 128'd0);
        check("hrst_drop",  128'(b_drop), 128'd0);
        check("hrst_addr",  128'(b_addr), 128'd0);
        step();
        en_b = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("hrst_count_after", 128'(b_count), 128'd1);

        // Clear on a due write slot
        step(); rst = 1'b1; mode = 1'b0;
        step(); rst = 1'b0; interval = 8'd2; en_b = 1'b1; k0 = cyc;
        for (int j = 0; j < 5; j++) push_b(k0 + 1 + 3 * j, j % 4);
        while (cyc < k0 + 15) step();
        clear = 1'b1;
        @(negedge clk);
        check("clr_wrapped_before", 128'(b_wrapped), 128'd1);
        check("clr_count_before", 128'(b_count), 128'd5);
        step();
        clear = 1'b0;
        push_b(k0 + 17, 0);
        @(negedge clk);
        check("clr_no_wren", 128'(b_wren), 128'd0);
        check("clr_wrapped", 128'(b_wrapped), 128'd0);
        check("clr_count", 128'(b_count), 128'd0);
        step();
        en_b = 1'b0;
        step();
        @(negedge clk);
        check("clr_count_after", 128'(b_count), 128'd1);
        check("clr_flags_after", 128'({b_full, b_wrapped}), 128'd0);

        repeat (3) step();
        check("a_queue_drained", 128'(exp_a_q.size()), 128'd0);
        check("b_queue_drained", 128'(exp_b_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
